// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle ALU ops and an iterative multi-step shifter
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_A = 4'd10;
  localparam logic [3:0] ALU_COPY_B = 4'd11;
  localparam logic [3:0] ALU_JALR   = 4'd12;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] acc, shifted, alu_res, wr_res;
  logic [3:0]      op;
  logic [4:0]      rd_q, wr_rd;
  logic [SW-1:0]   rem, rem_n, amt, shamt;
  logic            accept, is_shift, free, wr;

  assign shamt    = in_b[SW-1:0];
  assign free     = ~out_valid | out_ready;
  assign in_ready = (state == IDLE) & free & ~rst;
  assign accept   = in_valid & in_ready & ~flush;
  assign is_shift = (in_aluop == ALU_SLL) | (in_aluop == ALU_SRL) | (in_aluop == ALU_SRA);
  assign busy     = state != IDLE;
  assign amt      = ({1'b0, rem} > (SW+1)'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : rem;
  assign rem_n    = rem - amt;
  assign shifted  = (op == ALU_SLL) ? acc << amt :
                    (op == ALU_SRA) ? $unsigned($signed(acc) >>> amt) : acc >> amt;

  // single-cycle result; shift ops only land here with a zero shift amount, so they pass a through
  always_comb begin
    alu_res = '0;
    case (in_aluop)
      ALU_ADD:    alu_res = in_a + in_b;
      ALU_SUB:    alu_res = in_a - in_b;
      ALU_AND:    alu_res = in_a & in_b;
      ALU_OR:     alu_res = in_a | in_b;
      ALU_XOR:    alu_res = in_a ^ in_b;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_COPY_A: alu_res = in_a;
      ALU_COPY_B: alu_res = in_b;
      ALU_JALR:   alu_res = (in_a + in_b) & ~{{(XLEN-1){1'b0}}, 1'b1};
      default:    alu_res = '0;
    endcase
  end

  // next state and output-register write selection
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    wr_res  = alu_res;
    wr_rd   = in_rd;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && shamt != '0) state_n = SHIFT;
          else wr = 1'b1;
        end
      end
      SHIFT: begin
        wr_res = shifted;
        wr_rd  = rd_q;
        if (rem_n == '0) begin
          wr      = free;
          state_n = free ? IDLE : HOLD;
        end
      end
      HOLD: begin
        wr_res  = acc;
        wr_rd   = rd_q;
        wr      = free;
        state_n = free ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      wr      = 1'b0;
    end
  end

  // state, shifter datapath and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      op         <= '0;
      rd_q       <= '0;
      rem        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      state     <= state_n;
      out_valid <= ~flush & (wr | (out_valid & ~out_ready));
      if (wr) begin
        out_result <= wr_res;
        out_rd     <= wr_rd;
      end
      if (accept && is_shift) begin
        acc  <= in_a;
        op   <= in_aluop;
        rd_q <= in_rd;
        rem  <= shamt;
      end else if (state == SHIFT) begin
        acc <= shifted;
        rem <= rem_n;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  in_aluop;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;
  int          checks = 0;
  int          errors = 0;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    in_aluop = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    drive(op, a, b, rd);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, out_result, exp);
    check({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
  endtask

  task automatic shift_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp);
    int  n;
    bit  rdy_seen;
    drive(op, a, b, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    n        = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, out_result, exp);
    check({tag, "_ready_low"}, {31'd0, rdy_seen}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_aluop = '0; in_a = '0; in_b = '0; in_rd = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    single("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 5'd5, 32'h80000000);
    single("sub", 4'd1, 32'h5, 32'h7, 5'd6, 32'hFFFFFFFE);
    single("and", 4'd2, 32'hF0F0FFFF, 32'h0FF0F00F, 5'd7, 32'h00F0F00F);
    single("or", 4'd3, 32'hF0000000, 32'h0000000F, 5'd8, 32'hF000000F);
    single("xor", 4'd4, 32'hFFFF0000, 32'hFF00FF00, 5'd9, 32'h00FFFF00);
    single("sltu", 4'd6, 32'h1, 32'hFFFFFFFF, 5'd10, 32'h1);
    single("slt", 4'd5, 32'h1, 32'hFFFFFFFF, 5'd11, 32'h0);
    single("slt_neg", 4'd5, 32'h80000000, 32'h1, 5'd12, 32'h1);
    single("jalr", 4'd12, 32'h1001, 32'h0, 5'd13, 32'h1000);
    single("copy_a", 4'd10, 32'hDEADBEEF, 32'h1234, 5'd14, 32'hDEADBEEF);
    single("copy_b", 4'd11, 32'hDEADBEEF, 32'h1234, 5'd15, 32'h00001234);
    single("xxx", 4'd15, 32'hDEADBEEF, 32'h1234, 5'd16, 32'h0);
    single("sll0", 4'd7, 32'hCAFEF00D, 32'h20, 5'd17, 32'hCAFEF00D);
    @(negedge clk);
    check("drained", {31'd0, out_valid}, 32'd0);

    shift_op("sra31", 4'd9, 32'h80000000, 32'd31, 9, 32'hFFFFFFFF);
    shift_op("srl6", 4'd8, 32'hF0000000, 32'd6, 3, 32'h03C00000);
    shift_op("sll31", 4'd7, 32'h00000001, 32'd31, 9, 32'h80000000);
    shift_op("sra_pos", 4'd9, 32'h40000000, 32'd5, 3, 32'h02000000);
    @(negedge clk);

    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1, 5'd1);
    @(negedge clk);
    drive(4'd0, 32'd2, 32'd2, 5'd2);
    check("bp_v1", {31'd0, out_valid}, 32'd1);
    check("bp_r1", out_result, 32'd2);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("bp_r1_stable", out_result, 32'd2);
    check("bp_rd1_stable", {27'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_r2", out_result, 32'd4);
    check("bp_rd2", {27'd0, out_rd}, 32'd2);
    drive(4'd0, 32'd3, 32'd3, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_r3", out_result, 32'd6);
    check("bp_rd3", {27'd0, out_rd}, 32'd3);
    @(negedge clk);
    check("bp_done", {31'd0, out_valid}, 32'd0);

    drive(4'd9, 32'h80000000, 32'd20, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fl_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("fl_no_result", {31'd0, seen}, 32'd0);

    out_ready = 1'b0;
    single("fl_out_pre", 4'd0, 32'd10, 32'd20, 5'd21, 32'd30);
    flush = 1'b1;
    drive(4'd0, 32'd1, 32'd1, 5'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_clear", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("fl_in_ignored", {31'd0, out_valid}, 32'd0);

    single("rst_pre", 4'd0, 32'd100, 32'd23, 5'd22, 32'd123);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_result", out_result, 32'd0);
    check("rst2_rd", {27'd0, out_rd}, 32'd0);
    rst = 1'b0;
    #1 check("rst2_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
